play_engine: RTL and testbench
==============================

# play_engine

Playback engine sitting between the SRAM controller and the audio codec DAC pins. While `play` is held it walks the recorded region of SRAM forward or backward, applies fast/slow speed control with zero-order or linear interpolation, and serialises one 16-bit sample per `daclrc` frame onto `dacdat`. It replaces ad-hoc address and serialiser logic with one frame-scheduled FSM sharing the `addr` bus with the recording side.

## Interface
Parameters:
- `AW`, 18: SRAM word address width.
- `DW`, 16: sample width (signed two's complement).
- `RD_LAT`, 2: clocks from `rd_req` to valid `rd_data`.

Ports:
- `clk`  in  1: codec bit clock (bclk); the only clock.
- `reset`  in  1: asynchronous, active-high.
- `play`  in  1: level; engine runs while high.
- `inverse`  in  1: 1 = reverse playback.
- `speed`  in  1: 1 = fast mode (step = `number`), 0 = slow mode (stretch = `number`).
- `number`  in  4: speed factor; 0 treated as 1, >8 clamped to 8.
- `slowmethod`  in  1: 0 = zero-order hold, 1 = linear interpolation.
- `end_addr`  in  AW: last valid recorded address (inclusive).
- `daclrc`  in  1: DAC frame clock.
- `rd_req`  out  1: one-cycle SRAM read strobe.
- `addr`  out  AW: read address, stable from `rd_req` until data captured.
- `rd_data`  in  DW: SRAM read data.
- `dacdat`  out  1: serial DAC data.
- `done`  out  1: end of recording reached.

## Operation
- Frame start = rising edge of `daclrc`, detected by one register stage (`lrc_q`); all control inputs (`speed`, `number`, `slowmethod`, `inverse`) are sampled at frame start only.
- Position: sample index `n`, sub-step `k` (0..S-1, S = clamped slow factor; S = 1 in fast mode). Start of play: `n` = 0 (forward) or `end_addr` (reverse), `k` = 0.
- Per frame, after frame start: FSM IDLE → REQ0 (read `n`) → WAIT0 → REQ1 (read neighbour `n±1`; skipped when S = 1 or `slowmethod`=0) → WAIT1 → CALC → READY. READY waits for next frame start.
- Neighbour for interpolation: `n+1` forward, `n-1` reverse; at the last sample in the direction of travel, neighbour = `n` itself.
- CALC: zero-order y = s[n]; linear y = (s[n]·(S−k) + s[nb]·k) / S. Products and sum are signed 21-bit; division by a restoring sequential divider, ≤ 22 cycles, quotient truncated toward zero, result fits DW without saturation.
- Advance at end of CALC: slow mode k←k+1, on k = S−1 wrap to 0 and step `n` by 1; fast mode step `n` by F (clamped `number`). If S shrinks so k ≥ S at frame start, k←0 and `n` steps.
- End: if the next step would pass `end_addr` (forward) or go below 0 (reverse), set `done`, emit zeros thereafter, issue no further reads.
- `play` falling: abort any in-flight read/CALC, return to IDLE, `dacdat`=0, `done`=0, position reloaded at next `play` rise.

## Timing
- Reset values: `rd_req`=0, `addr`=0, `dacdat`=0, `done`=0, FSM=IDLE, `n`=0, `k`=0, output register 0.
- Latency: sample computed in frame N is shifted out starting frame N+1 (one-frame pipeline); first frame after `play` rise outputs zeros.
- Serialiser: left-justified, MSB first; bit 15 on `dacdat` the cycle after frame-start detection, one bit per clock, then zeros until next frame; same sample on both channels (also restarts on `daclrc` falling edge).
- `rd_data` captured exactly RD_LAT clocks after `rd_req`; `addr` held during that window.
- Budget: worst-case frame work (2 reads + divide) ≤ 32 clocks; clock requirement ≥ 64 clk per `daclrc` period. If a frame start arrives before READY, the previous output sample is repeated and computation continues.
- `done` rises in the clock after the terminal CALC; holds until `play` low or `reset`.

## Structure
- Shared package: sample width, address width, speed clamp limits (1, 8), FSM state encoding.
- One sub-module: `seq_divider` (signed 21-bit ÷ 4-bit unsigned, start/busy/done handshake, truncating).

## Test plan
- Forward, fast, `number`=1, `end_addr`=3, memory {100,200,300,400} → `dacdat` frames 0,100,200,300,400, then `done`=1 and zeros.
- Fast `number`=3, `end_addr`=9, mem[i]=i → output 0,3,6,9 then `done`.
- Slow S=4, `slowmethod`=1, s0=0, s1=400 → 0,100,200,300,400; with `slowmethod`=0 → 0,0,0,0,400.
- Linear with negatives: S=3, s0=−100, s1=200 → −100, 0, 100 (truncation toward zero checked for S=3, s0=0, s1=−1 → 0,0).
- `inverse`=1, `end_addr`=2, mem {10,20,30} → 30,20,10, `done`; `number`=0 and 12 behave as 1 and 8.
- `play` dropped mid-divide, then reasserted; `reset` mid-frame → outputs at reset values, replay restarts at address 0.

Source files
------------

// File: rtl/play_engine_pkg.sv
// Shared types and limits for the playback engine: widths, speed clamp,
// control snapshot and FSM encoding.
package play_engine_pkg;
  localparam int AW_DEF = 18;
  localparam int DW_DEF = 16;
  localparam int NUM_W  = 21;
  localparam logic [3:0] SPD_MIN = 4'd1;
  localparam logic [3:0] SPD_MAX = 4'd8;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, CALC, READY} state_t;

  // Control inputs as sampled at frame start.
  typedef struct packed {
    logic       inverse;
    logic       fast;
    logic       linear;
    logic [3:0] factor;
  } ctl_t;

  function automatic logic [3:0] clamp_speed(input logic [3:0] num);
    if (num < SPD_MIN) return SPD_MIN;
    if (num > SPD_MAX) return SPD_MAX;
    return num;
  endfunction
endpackage

// File: rtl/play_engine_seq_divider.sv
// Restoring sequential divider: signed dividend / unsigned divisor,
// quotient truncated toward zero; one bit per clock after start.
module seq_divider #(
  parameter int NW  = 21,
  parameter int DVW = 4,
  parameter int QW  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 abort,
  input  logic                 start,
  input  logic signed [NW-1:0] dividend,
  input  logic [DVW-1:0]       divisor,
  output logic                 busy,
  output logic                 done,
  output logic signed [QW-1:0] quotient
);
  localparam int CW = $clog2(NW + 1);

  logic [NW-1:0]  q_q;
  logic [DVW-1:0] rem_q, dv_q, diff;
  logic [DVW:0]   trial;
  logic           neg_q, ge;
  logic [CW-1:0]  cnt_q;

  // Divide magnitudes, then restore the sign so rounding is toward zero.
  assign trial    = {rem_q, q_q[NW-1]};
  assign ge       = trial >= {1'b0, dv_q};
  assign diff     = trial[DVW-1:0] - dv_q;
  assign quotient = QW'(neg_q ? -q_q : q_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q   <= '0;
      rem_q <= '0;
      dv_q  <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      q_q   <= dividend[NW-1] ? NW'(-dividend) : NW'(dividend);
      rem_q <= '0;
      dv_q  <= divisor;
      neg_q <= dividend[NW-1];
      cnt_q <= CW'(NW);
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (busy) begin
      q_q   <= {q_q[NW-2:0], ge};
      rem_q <= ge ? diff : trial[DVW-1:0];
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end
endmodule

// File: rtl/play_engine.sv
// Frame-scheduled SRAM playback: fetches, optionally interpolates, and
// serialises one sample per daclrc frame onto dacdat.
module play_engine
  import play_engine_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          play,
  input  logic          inverse,
  input  logic          speed,
  input  logic [3:0]    number,
  input  logic          slowmethod,
  input  logic [AW-1:0] end_addr,
  input  logic          daclrc,
  output logic          rd_req,
  output logic [AW-1:0] addr,
  input  logic [DW-1:0] rd_data,
  output logic          dacdat,
  output logic          done
);
  state_t state, state_nx;
  ctl_t   ctl_q, ctl_in;

  logic                    lrc_q, frame_start, lrc_fall;
  logic [AW-1:0]           n_q, nb, n_adv;
  logic [AW:0]             n_fwd;
  logic [3:0]              k_q, s_fac, s_new, step, wcnt;
  logic                    linear, wrap, term, fs_fix, fs_term, calc_fin;
  logic signed [DW-1:0]    s0_q, s1_q, y_q, out_q, load_val, quo;
  logic [DW-1:0]           sh_q;
  logic signed [NUM_W-1:0] s0x, s1x, wa, wb, num;
  logic                    div_go, div_busy, div_done, div_started;

  assign frame_start = daclrc & ~lrc_q;
  assign lrc_fall    = ~daclrc & lrc_q;

  assign ctl_in = '{inverse: inverse, fast: speed, linear: slowmethod,
                    factor: clamp_speed(number)};
  assign s_fac  = ctl_q.fast ? 4'd1 : ctl_q.factor;
  assign s_new  = speed ? 4'd1 : ctl_in.factor;
  assign step   = ctl_q.fast ? ctl_q.factor : 4'd1;
  assign linear = ctl_q.linear && (s_fac != 4'd1);

  // Neighbour sample; at the last sample in the travel direction reuse n.
  assign nb = ctl_q.inverse ? ((n_q == '0) ? n_q : n_q - AW'(1))
                            : ((n_q >= end_addr) ? n_q : n_q + AW'(1));

  assign wrap  = (k_q >= s_fac - 4'd1);
  assign n_fwd = {1'b0, n_q} + (AW+1)'(step);
  assign term  = ctl_q.inverse ? (n_q < AW'(step)) : (n_fwd > {1'b0, end_addr});
  assign n_adv = ctl_q.inverse ? n_q - AW'(step) : n_fwd[AW-1:0];

  // Slow factor shrank below the current sub-step: jump to the next sample.
  assign fs_fix  = (k_q >= s_new);
  assign fs_term = inverse ? (n_q == '0) : (n_q >= end_addr);

  assign addr     = (state == REQ1 || state == WAIT1) ? nb : n_q;
  assign rd_req   = play && (state == REQ0 || state == REQ1);
  assign calc_fin = (state == CALC) && (!linear || div_done);
  assign load_val = (state == READY) ? y_q : out_q;

  assign s0x = {{(NUM_W-DW){s0_q[DW-1]}}, s0_q};
  assign s1x = {{(NUM_W-DW){s1_q[DW-1]}}, s1_q};
  assign wa  = {{(NUM_W-4){1'b0}}, s_fac - k_q};
  assign wb  = {{(NUM_W-4){1'b0}}, k_q};
  assign num = s0x * wa + s1x * wb;

  seq_divider #(.NW(NUM_W), .DVW(4), .QW(DW)) u_div (
    .clk(clk), .reset(reset), .abort(!play), .start(div_go),
    .dividend(num), .divisor(s_fac),
    .busy(div_busy), .done(div_done), .quotient(quo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lrc_q <= 1'b0;
      state <= IDLE;
    end else begin
      lrc_q <= daclrc;
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    div_go   = 1'b0;
    if (!play) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (frame_start) state_nx = REQ0;
        REQ0:    state_nx = WAIT0;
        WAIT0:   if (wcnt == 4'(RD_LAT)) state_nx = linear ? REQ1 : CALC;
        REQ1:    state_nx = WAIT1;
        WAIT1:   if (wcnt == 4'(RD_LAT)) state_nx = CALC;
        CALC:    begin
          div_go = linear && !div_started && !div_busy;
          if (calc_fin) state_nx = READY;
        end
        READY:   if (frame_start && !done && !(fs_fix && fs_term)) state_nx = REQ0;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_q <= '0; n_q <= '0; k_q <= '0; wcnt <= '0;
      s0_q <= '0; s1_q <= '0; y_q <= '0; out_q <= '0; sh_q <= '0;
      dacdat <= 1'b0; done <= 1'b0; div_started <= 1'b0;
    end else if (!play) begin
      n_q <= '0; k_q <= '0; y_q <= '0; out_q <= '0; sh_q <= '0;
      dacdat <= 1'b0; done <= 1'b0; div_started <= 1'b0;
    end else begin
      if (frame_start) begin
        out_q  <= load_val;
        sh_q   <= {load_val[DW-2:0], 1'b0};
        dacdat <= load_val[DW-1];
      end else if (lrc_fall) begin
        sh_q   <= {out_q[DW-2:0], 1'b0};
        dacdat <= out_q[DW-1];
      end else begin
        sh_q   <= {sh_q[DW-2:0], 1'b0};
        dacdat <= sh_q[DW-1];
      end

      if (frame_start && state == IDLE) begin
        ctl_q <= ctl_in;
        n_q   <= inverse ? end_addr : '0;
        k_q   <= '0;
      end else if (frame_start && state == READY) begin
        if (done) begin
          y_q <= '0;
        end else begin
          ctl_q <= ctl_in;
          if (fs_fix) begin
            k_q <= '0;
            if (fs_term) done <= 1'b1;
            else         n_q  <= inverse ? n_q - AW'(1) : n_q + AW'(1);
          end
        end
      end

      if (state == REQ0 || state == REQ1) wcnt <= 4'd1;
      else if (state == WAIT0 || state == WAIT1) wcnt <= wcnt + 4'd1;
      if (state == WAIT0 && wcnt == 4'(RD_LAT)) s0_q <= rd_data;
      if (state == WAIT1 && wcnt == 4'(RD_LAT)) s1_q <= rd_data;

      if (div_go) div_started <= 1'b1;
      else if (state != CALC || calc_fin) div_started <= 1'b0;

      if (calc_fin) begin
        y_q <= linear ? quo : s0_q;
        if (wrap) begin
          k_q <= '0;
          if (term) done <= 1'b1;
          else      n_q  <= n_adv;
        end else begin
          k_q <= k_q + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_play_engine.sv
// Directed bench for play_engine: SRAM model with fixed read latency,
// frame-accurate daclrc and serial capture of both channels.
module tb_play_engine;
  localparam int AW = 18, DW = 16, RD_LAT = 2;

  logic          clk = 1'b0;
  logic          reset, play, inverse, speed, slowmethod, daclrc;
  logic [3:0]    number;
  logic [AW-1:0] end_addr, addr;
  logic          rd_req, dacdat, done;
  logic [DW-1:0] rd_data = '0, p1 = '0;
  logic [DW-1:0] mem [0:31];
  logic [DW-1:0] expq [$];
  int checks = 0, failures = 0, rd_cnt = 0, c0;

  always #5 clk = ~clk;

  play_engine #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .play(play), .inverse(inverse), .speed(speed),
    .number(number), .slowmethod(slowmethod), .end_addr(end_addr),
    .daclrc(daclrc), .rd_req(rd_req), .addr(addr), .rd_data(rd_data),
    .dacdat(dacdat), .done(done)
  );

  // Data is only valid exactly RD_LAT clocks after the strobe.
  always @(posedge clk) begin
    p1      <= rd_req ? mem[addr[4:0]] : 16'hDEAD;
    rd_data <= p1;
    if (rd_req) rd_cnt <= rd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic frame(output logic [DW-1:0] l, output logic [DW-1:0] r);
    @(negedge clk); daclrc = 1'b1; l = '0;
    for (int i = 0; i < DW; i++) begin @(posedge clk); #1; l = {l[DW-2:0], dacdat}; end
    repeat (17) @(negedge clk);
    daclrc = 1'b0; r = '0;
    for (int i = 0; i < DW; i++) begin @(posedge clk); #1; r = {r[DW-2:0], dacdat}; end
    repeat (17) @(negedge clk);
  endtask

  task automatic play_seq(input string tag);
    logic [DW-1:0] l, r;
    foreach (expq[i]) begin
      frame(l, r);
      chk($sformatf("%s_L%0d", tag, i), 32'(l), 32'(expq[i]));
      chk($sformatf("%s_R%0d", tag, i), 32'(r), 32'(expq[i]));
    end
  endtask

  task automatic start(input logic inv, input logic spd, input logic [3:0] num,
                       input logic sm, input logic [AW-1:0] ea);
    @(negedge clk); play = 1'b0;
    @(negedge clk);
    inverse = inv; speed = spd; number = num; slowmethod = sm; end_addr = ea;
    play = 1'b1;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 32; i++) mem[i] = 16'(i);
  endtask

  initial begin
    reset = 1'b1; play = 1'b0; inverse = 1'b0; speed = 1'b1; number = 4'd1;
    slowmethod = 1'b0; daclrc = 1'b0; end_addr = '0;
    fill_ramp();
    repeat (3) @(negedge clk);
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_dacdat", 32'(dacdat), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;

    // forward fast x1
    mem[0] = 16'd100; mem[1] = 16'd200; mem[2] = 16'd300; mem[3] = 16'd400;
    start(1'b0, 1'b1, 4'd1, 1'b0, 18'd3);
    c0 = rd_cnt;
    expq = '{16'd0, 16'd100, 16'd200}; play_seq("fwd1");
    chk("fwd1_done_early", 32'(done), 0);
    expq = '{16'd300}; play_seq("fwd1b");
    chk("fwd1_done", 32'(done), 1);
    chk("fwd1_reads", 32'(rd_cnt - c0), 4);
    expq = '{16'd400, 16'd0, 16'd0}; play_seq("fwd1_tail");
    chk("fwd1_noreads", 32'(rd_cnt - c0), 4);
    chk("fwd1_done_hold", 32'(done), 1);

    // fast x3 over a ramp
    fill_ramp();
    start(1'b0, 1'b1, 4'd3, 1'b0, 18'd9);
    expq = '{16'd0, 16'd0, 16'd3, 16'd6, 16'd9, 16'd0}; play_seq("fast3");
    chk("fast3_done", 32'(done), 1);

    // slow x4, linear then zero-order
    mem[0] = 16'd0; mem[1] = 16'd400;
    start(1'b0, 1'b0, 4'd4, 1'b1, 18'd1);
    expq = '{16'd0, 16'd0, 16'd100, 16'd200, 16'd300, 16'd400}; play_seq("lin4");
    start(1'b0, 1'b0, 4'd4, 1'b0, 18'd1);
    expq = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd400}; play_seq("zoh4");

    // negative interpolation and truncation toward zero
    mem[0] = 16'hFF9C; mem[1] = 16'd200;
    start(1'b0, 1'b0, 4'd3, 1'b1, 18'd1);
    expq = '{16'd0, 16'hFF9C, 16'd0, 16'd100, 16'd200}; play_seq("neg3");
    mem[0] = 16'd0; mem[1] = 16'hFFFF;
    start(1'b0, 1'b0, 4'd3, 1'b1, 18'd1);
    expq = '{16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF}; play_seq("trunc3");

    // reverse playback
    mem[0] = 16'd10; mem[1] = 16'd20; mem[2] = 16'd30;
    start(1'b1, 1'b1, 4'd1, 1'b0, 18'd2);
    expq = '{16'd0, 16'd30, 16'd20, 16'd10, 16'd0}; play_seq("rev");
    chk("rev_done", 32'(done), 1);

    // speed clamp: 0 -> 1, 12 -> 8
    fill_ramp();
    start(1'b0, 1'b1, 4'd0, 1'b0, 18'd20);
    expq = '{16'd0, 16'd0, 16'd1, 16'd2}; play_seq("num0");
    start(1'b0, 1'b1, 4'd12, 1'b0, 18'd20);
    expq = '{16'd0, 16'd0, 16'd8, 16'd16, 16'd0}; play_seq("num12");
    chk("num12_done", 32'(done), 1);

    // play dropped while the divider is running
    mem[0] = 16'd0; mem[1] = 16'd400;
    start(1'b0, 1'b0, 4'd4, 1'b1, 18'd1);
    expq = '{16'd0, 16'd0}; play_seq("drop_pre");
    @(negedge clk); daclrc = 1'b1;
    repeat (15) @(negedge clk);
    play = 1'b0;
    @(negedge clk);
    chk("drop_dacdat", 32'(dacdat), 0);
    chk("drop_done", 32'(done), 0);
    chk("drop_rd_req", 32'(rd_req), 0);
    repeat (17) @(negedge clk); daclrc = 1'b0;
    repeat (33) @(negedge clk);
    play = 1'b1;
    expq = '{16'd0, 16'd0, 16'd100, 16'd200}; play_seq("drop_post");

    // reset in the middle of a frame
    mem[0] = 16'd100; mem[1] = 16'd200; mem[2] = 16'd300; mem[3] = 16'd400;
    start(1'b0, 1'b1, 4'd1, 1'b0, 18'd3);
    expq = '{16'd0, 16'd100}; play_seq("rst_pre");
    @(negedge clk); daclrc = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1; #1;
    chk("midrst_rd_req", 32'(rd_req), 0);
    chk("midrst_addr", 32'(addr), 0);
    chk("midrst_dacdat", 32'(dacdat), 0);
    chk("midrst_done", 32'(done), 0);
    repeat (30) @(negedge clk); daclrc = 1'b0;
    repeat (5) @(negedge clk); reset = 1'b0;
    repeat (28) @(negedge clk);
    expq = '{16'd0, 16'd100, 16'd200}; play_seq("rst_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
